// File: rtl/pll_reset_sequencer_if.sv
// Signals between the PLL reset sequencer and its PLL / system neighbours.
// There is no valid/ready handshake: ready is a level status, high only while the sequencer is in RUN.
interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [2:0] seq_state;
  logic [7:0] lock_loss_cnt;

  modport master (
    input  pll_locked,
    output pll_rst, sys_rst, ready, seq_state, lock_loss_cnt
  );

  modport slave (
    output pll_locked,
    input  pll_rst, sys_rst, ready, seq_state, lock_loss_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases system reset.
// Optional lock-loss event counter enabled by defining LOCK_LOSS_COUNTER_EN.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 5000000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RESET_HOLD_CYCLES   = 256
) (
  input  logic                         refclk,
  input  logic                         rst,
  pll_reset_sequencer_if.master        bus
);

  typedef enum logic [2:0] {
    S_PLLRST = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_HOLD   = 3'd3,
    S_RUN    = 3'd4
  } state_t;

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CD  = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // A state lasting N cycles leaves on the edge where the counter reads N-1.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic                   pll_rst_q;
  logic                   sys_rst_q;
  logic                   ready_q;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_nxt = state;
    case (state)
      S_PLLRST: if (cnt == RST_LAST) state_nxt = S_WAIT;
      S_WAIT: begin
        if (locked_s)                  state_nxt = S_STABLE;
        else if (cnt == TIMEOUT_LAST)  state_nxt = S_PLLRST;
      end
      S_STABLE: begin
        if (!locked_s)                 state_nxt = S_WAIT;
        else if (cnt == STABLE_LAST)   state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (!locked_s)                 state_nxt = S_WAIT;
        else if (cnt == HOLD_LAST)     state_nxt = S_RUN;
      end
      S_RUN: if (!locked_s) state_nxt = S_WAIT;
      default: state_nxt = S_PLLRST;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      state     <= S_PLLRST;
      cnt       <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
      state  <= state_nxt;
      // RUN has no exit count, so the counter parks at zero there and can never wrap.
      if (state_nxt != state || state_nxt == S_RUN) cnt <= '0;
      else                                          cnt <= cnt + CNT_W'(1);
      pll_rst_q <= (state_nxt == S_PLLRST);
      sys_rst_q <= (state_nxt != S_RUN);
      ready_q   <= (state_nxt == S_RUN);
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.ready     = ready_q;
  assign bus.seq_state = state;

`ifdef LOCK_LOSS_COUNTER_EN
  logic [7:0] loss_q;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_q <= 8'd0;
    end else if (state == S_RUN && state_nxt == S_WAIT && loss_q != 8'hFF) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign bus.lock_loss_cnt = loss_q;
`else
  assign bus.lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: every output change is an event checked against a queue of
// expected {cycle, outputs} entries pushed by the stimulus process.
module tb_pll_reset_sequencer;

  localparam int OW = 14;
  localparam int W  = 32 + OW;

  localparam logic [2:0] ST_PLLRST = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_STABLE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;

  logic        refclk;
  logic        rst;
  logic [31:0] cyc;
  int          checks;
  int          errors;
  logic [7:0]  exp_llc;
  logic [W-1:0] exp_q[$];

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .SYNC_STAGES         (2),
    .PLL_RST_CYCLES      (3),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_STABLE_CYCLES  (8),
    .RESET_HOLD_CYCLES   (4)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus.master)
  );

  // clock / cycle counter
  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  initial cyc = '0;
  always @(posedge refclk) cyc <= cyc + 32'd1;

  function automatic logic [OW-1:0] mk(input logic pr, input logic sr, input logic rd,
                                       input logic [2:0] st, input logic [7:0] llc);
    return {pr, sr, rd, st, llc};
  endfunction

  task automatic expect_at(input logic [31:0] at, input logic [OW-1:0] v);
    exp_q.push_back({at, v});
  endtask

  // Returns just after the falling edge at which cyc == target.
  task automatic wait_drive(input logic [31:0] target);
    @(negedge refclk);
    while (cyc < target) @(negedge refclk);
    #1;
  endtask

  task automatic note_loss();
`ifdef LOCK_LOSS_COUNTER_EN
    if (exp_llc != 8'd255) exp_llc = exp_llc + 8'd1;
`endif
  endtask

  // Release rst with pll_locked high: WAIT at +3, STABLE at +4, HOLD at +12, RUN at +16.
  task automatic release_full();
    logic [31:0] t;
    t = cyc;
    rst = 1'b0;
    expect_at(t + 3,  mk(1'b0, 1'b1, 1'b0, ST_WAIT,   exp_llc));
    expect_at(t + 4,  mk(1'b0, 1'b1, 1'b0, ST_STABLE, exp_llc));
    expect_at(t + 12, mk(1'b0, 1'b1, 1'b0, ST_HOLD,   exp_llc));
    expect_at(t + 16, mk(1'b0, 1'b0, 1'b1, ST_RUN,    exp_llc));
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    exp_llc = 8'd0;
    expect_at(cyc + 1, mk(1'b1, 1'b1, 1'b0, ST_PLLRST, 8'd0));
  endtask

  // monitor / scoreboard
  initial begin
    logic [OW-1:0] prev;
    logic [OW-1:0] cur;
    logic [W-1:0]  e;
    prev = '1;
    forever begin
      @(negedge refclk);
      cur = {bus.pll_rst, bus.sys_rst, bus.ready, bus.seq_state, bus.lock_loss_cnt};
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL evt: outputs %h at cycle %0d, no event required", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e !== {cyc, cur}) begin
            errors++;
            $display("FAIL evt: got cycle %0d outputs %h, required cycle %0d outputs %h",
                     cyc, cur, e[W-1:OW], e[OW-1:0]);
          end
        end
      end
      prev = cur;
    end
  end

  // stimulus
  initial begin
    logic [31:0] t;
    logic [31:0] d;
    logic [31:0] r;
    int          waited;
    checks = 0;
    errors = 0;
    exp_llc = 8'd0;
    rst = 1'b0;
    bus.pll_locked = 1'b1;
    expect_at(1, mk(1'b1, 1'b1, 1'b0, ST_PLLRST, 8'd0));
    #1 rst = 1'b1;

    // locked throughout: full sequence to RUN
    wait_drive(3);
    t = cyc;
    release_full();

    // lock loss in RUN: WAIT three edges later, pll_rst stays low
    wait_drive(t + 20);
    d = cyc;
    bus.pll_locked = 1'b0;
    note_loss();
    expect_at(d + 3, mk(1'b0, 1'b1, 1'b0, ST_WAIT, exp_llc));
    wait_drive(d + 10);
    r = cyc;
    bus.pll_locked = 1'b1;
    expect_at(r + 3, mk(1'b0, 1'b1, 1'b0, ST_STABLE, exp_llc));

    // two-cycle dropout mid-STABLE: back to WAIT, then a full 8-cycle stable count
    wait_drive(r + 7);
    d = cyc;
    bus.pll_locked = 1'b0;
    expect_at(d + 3, mk(1'b0, 1'b1, 1'b0, ST_WAIT, exp_llc));
    wait_drive(d + 2);
    r = cyc;
    bus.pll_locked = 1'b1;
    expect_at(r + 3,  mk(1'b0, 1'b1, 1'b0, ST_STABLE, exp_llc));
    expect_at(r + 11, mk(1'b0, 1'b1, 1'b0, ST_HOLD,   exp_llc));

    // rst during HOLD: outputs return to reset values without waiting for a clock
    wait_drive(r + 12);
    assert_rst();
    #1;
    checks++;
    if ({bus.pll_rst, bus.sys_rst, bus.ready, bus.seq_state} !== 6'b110000) begin
      errors++;
      $display("FAIL rst_async: got %b, required 110000",
               {bus.pll_rst, bus.sys_rst, bus.ready, bus.seq_state});
    end
    wait_drive(cyc + 2);
    t = cyc;
    release_full();

    // never locked: pll_rst re-pulses 3 wide every 35 cycles
    wait_drive(t + 20);
    assert_rst();
    bus.pll_locked = 1'b0;
    wait_drive(cyc + 2);
    t = cyc;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_at(t + 3 + 35 * k,  mk(1'b0, 1'b1, 1'b0, ST_WAIT,   8'd0));
      expect_at(t + 35 + 35 * k, mk(1'b1, 1'b1, 1'b0, ST_PLLRST, 8'd0));
    end
    expect_at(t + 108, mk(1'b0, 1'b1, 1'b0, ST_WAIT, 8'd0));
    wait_drive(t + 113);
    assert_rst();
    bus.pll_locked = 1'b1;
    wait_drive(cyc + 2);
    t = cyc;
    release_full();

    // 300 lock losses from RUN: counter saturates at 255
    wait_drive(t + 20);
    for (int i = 0; i < 300; i++) begin
      d = cyc;
      bus.pll_locked = 1'b0;
      note_loss();
      expect_at(d + 3, mk(1'b0, 1'b1, 1'b0, ST_WAIT, exp_llc));
      wait_drive(d + 4);
      r = cyc;
      bus.pll_locked = 1'b1;
      expect_at(r + 3,  mk(1'b0, 1'b1, 1'b0, ST_STABLE, exp_llc));
      expect_at(r + 11, mk(1'b0, 1'b1, 1'b0, ST_HOLD,   exp_llc));
      expect_at(r + 15, mk(1'b0, 1'b0, 1'b1, ST_RUN,    exp_llc));
      wait_drive(r + 18);
    end

    checks++;
`ifdef LOCK_LOSS_COUNTER_EN
    if (bus.lock_loss_cnt !== 8'd255) begin
      errors++;
      $display("FAIL llc_final: got %0d, required 255", bus.lock_loss_cnt);
    end
`else
    if (bus.lock_loss_cnt !== 8'd0) begin
      errors++;
      $display("FAIL llc_final: got %0d, required 0", bus.lock_loss_cnt);
    end
`endif

    // final report
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(negedge refclk);
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
